i2c_target_responder: RTL and testbench

// - Synthesizable I2C target (slave) that answers a single 7-bit address; responder end of the bus the i2c agent drives as initiator.
// - Oversamples SCL/SDA on the system clock, detects START/STOP, ACKs its address, and moves bytes to/from a local byte handshake.
// - Sits between the open-drain pad cells and a register/FIFO client. Standard- and fast-mode only.

---
 rtl/i2c_target_responder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder.sv
// ---------------------------------------------------------------------------
// i2c_target_responder
//
// I2C target (slave) answering one 7-bit address. SCL/SDA are oversampled on
// the system clock. START/STOP are detected and ACKed address/data bytes are
// moved to and from a simple local byte handshake. Standard/fast mode only.
//
// Optional feature macro: I2C_CLK_STRETCH_EN
//   defined   - if no read byte is buffered when a read byte must start, SCL
//               is held low until tx_valid_i delivers one.
//   undefined - scl_oe_o is tied 0 and an empty buffer sends 8'hFF.
//
// Ports
//   clk_i       system clock (SCL phases must last >= SYNC_STAGES+3 cycles)
//   rst_n_i     asynchronous active-low reset
//   scl_i       SCL pad input
//   sda_i       SDA pad input
//   sda_oe_o    1 = pull SDA low
//   scl_oe_o    1 = pull SCL low (clock stretch)
//   start_o     1-cycle pulse on START / repeated START
//   stop_o      1-cycle pulse on STOP
//   rw_o        R/W bit of the last matched address (1 = read)
//   busy_o      high from address match until STOP or next START
//   rx_data_o   last byte written by the initiator
//   rx_valid_o  1-cycle pulse when rx_data_o updates
//   tx_req_o    1-cycle pulse requesting the next read byte
//   tx_data_i   read byte, sampled when tx_valid_i = 1
//   tx_valid_i  single-cycle qualifier for tx_data_i
// ---------------------------------------------------------------------------
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       scl_oe_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       rw_o,
  output logic       busy_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_req_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i
);

`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic [7:0]             tx_shift;
  logic [7:0]             tx_buf;
  logic                   tx_full;
  logic                   tx_avail;
  logic [7:0]             tx_next;
  logic                   scl_hold;

  // Synchronizers reset to 1 so the idle bus never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_hist <= scl_s;
      sda_hist <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist;
  assign scl_fall  = ~scl_s & scl_hist;
  assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
  assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;

  // A tx_valid_i arriving on the very cycle a read byte starts is used
  // directly, so it is never lost between buffer and shifter.
  assign tx_avail = tx_full | tx_valid_i;
  assign tx_next  = tx_valid_i ? tx_data_i : tx_buf;

`ifdef I2C_CLK_STRETCH_EN
  assign scl_oe_o = scl_hold;
`else
  assign scl_oe_o = 1'b0;
`endif

  // Protocol FSM. START/STOP take priority over everything else; the bit
  // counter counts synced SCL rises and is cleared at each ACK-slot fall.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shift_reg  <= 8'h00;
      tx_shift   <= 8'hFF;
      tx_buf     <= 8'h00;
      tx_full    <= 1'b0;
      scl_hold   <= 1'b0;
      sda_oe_o   <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      rw_o       <= 1'b0;
      busy_o     <= 1'b0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
    end else begin
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;

      // Buffer load sits before the FSM so a read-byte start can empty it.
      if (tx_valid_i && state != RD_DATA) begin
        tx_buf  <= tx_data_i;
        tx_full <= 1'b1;
      end

      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        sda_oe_o <= 1'b0;
        scl_hold <= 1'b0;
        busy_o   <= 1'b0;
        start_o  <= 1'b1;
      end else if (stop_det) begin
        state    <= IDLE;
        bit_cnt  <= 4'd0;
        sda_oe_o <= 1'b0;
        scl_hold <= 1'b0;
        busy_o   <= 1'b0;
        stop_o   <= 1'b1;
      end else begin
        if (scl_rise) begin
          bit_cnt <= bit_cnt + 4'd1;
        end

        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda_s};
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shift_reg[7:1] == TARGET_ADDR) begin
                rw_o     <= shift_reg[0];
                busy_o   <= 1'b1;
                sda_oe_o <= 1'b1;
                tx_req_o <= shift_reg[0];
                state    <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall && bit_cnt == 4'd9) begin
              bit_cnt  <= 4'd0;
              sda_oe_o <= 1'b0;
              if (!rw_o) begin
                state <= WR_DATA;
              end else begin
                state   <= RD_DATA;
                tx_full <= 1'b0;
                if (tx_avail) begin
                  tx_shift <= tx_next;
                  sda_oe_o <= ~tx_next[7];
                end else begin
                  tx_shift <= 8'hFF;
                  scl_hold <= STRETCH_EN;
                end
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda_s};
            end else if (scl_fall && bit_cnt == 4'd8) begin
              rx_data_o  <= shift_reg;
              rx_valid_o <= 1'b1;
              sda_oe_o   <= 1'b1;
              state      <= WR_ACK;
            end
          end

          WR_ACK: begin
            if (scl_fall && bit_cnt == 4'd9) begin
              bit_cnt  <= 4'd0;
              sda_oe_o <= 1'b0;
              state    <= WR_DATA;
            end
          end

          RD_DATA: begin
            // While stretching, the first byte goes straight to the shifter
            // so its MSB is on SDA when SCL is let go.
            if (scl_hold) begin
              if (tx_valid_i) begin
                tx_shift <= tx_data_i;
                sda_oe_o <= ~tx_data_i[7];
                scl_hold <= 1'b0;
              end
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe_o <= 1'b0;
                state    <= RD_ACK;
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b1};
                sda_oe_o <= ~tx_shift[6];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                tx_req_o <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end else if (scl_fall && bit_cnt == 4'd9) begin
              bit_cnt <= 4'd0;
              state   <= RD_DATA;
              tx_full <= 1'b0;
              if (tx_avail) begin
                tx_shift <= tx_next;
                sda_oe_o <= ~tx_next[7];
              end else begin
                tx_shift <= 8'hFF;
                sda_oe_o <= 1'b0;
                scl_hold <= STRETCH_EN;
              end
            end
          end

          IDLE, IGNORE: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_responder
//
// Directed bench for i2c_target_responder. Acts as a bit-banged I2C initiator
// on a wired-AND bus model and as the local read-byte supplier.
// ---------------------------------------------------------------------------
module tb_i2c_target_responder;

`ifdef I2C_CLK_STRETCH_EN
  localparam bit         STRETCH  = 1'b1;
  localparam logic [7:0] LATE_EXP = 8'h3C;
`else
  localparam bit         STRETCH  = 1'b0;
  localparam logic [7:0] LATE_EXP = 8'hFF;
`endif

  localparam int Q = 5;

  logic       clk;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       scl_line;
  logic       sda_line;
  logic       sda_oe;
  logic       scl_oe;
  logic       start_p;
  logic       stop_p;
  logic       rw;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_valid;

  int assertions = 0;
  int failures   = 0;

  int start_cnt, stop_cnt, rx_valid_cnt, tx_req_cnt;
  int sda_oe_cycles, busy_cycles;
  int scl_oe_cycles = 0;
  logic [7:0] rx_log[$];

  logic [7:0] tx_bytes[4];
  int         tx_idx   = 0;
  int         tx_delay = 2;
  logic       scl_oe_at_valid;
  logic       scl_oe_after_valid;

  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  i2c_target_responder #(
    .TARGET_ADDR(7'h22),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .scl_i     (scl_line),
    .sda_i     (sda_line),
    .sda_oe_o  (sda_oe),
    .scl_oe_o  (scl_oe),
    .start_o   (start_p),
    .stop_o    (stop_p),
    .rw_o      (rw),
    .busy_o    (busy),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .tx_req_o  (tx_req),
    .tx_data_i (tx_data),
    .tx_valid_i(tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (start_p)  start_cnt++;
    if (stop_p)   stop_cnt++;
    if (tx_req)   tx_req_cnt++;
    if (sda_oe)   sda_oe_cycles++;
    if (busy)     busy_cycles++;
    if (scl_oe)   scl_oe_cycles++;
    if (rx_valid) begin
      rx_valid_cnt++;
      rx_log.push_back(rx_data);
    end
  end

  // Local read-byte supplier: answers each tx_req after tx_delay cycles.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_req) begin
        repeat (tx_delay - 1) @(negedge clk);
        tx_data         = tx_bytes[tx_idx % 4];
        tx_idx++;
        tx_valid        = 1'b1;
        scl_oe_at_valid = scl_oe;
        @(negedge clk);
        tx_valid           = 1'b0;
        scl_oe_after_valid = scl_oe;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counters();
    start_cnt     = 0;
    stop_cnt      = 0;
    rx_valid_cnt  = 0;
    tx_req_cnt    = 0;
    sda_oe_cycles = 0;
    busy_cycles   = 0;
    rx_log.delete();
  endtask

  // Bounded wait for SCL to actually go high (target may stretch).
  task automatic raise_scl();
    int n;
    n = 0;
    scl_m = 1'b1;
    #1;
    while (!scl_line && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!scl_line) checkOutput("scl_release_timeout", 32'(scl_line), 32'd1);
  endtask

  task automatic clock_bit(input logic b, output logic sampled);
    sda_m = b;
    wait_cycles(Q);
    raise_scl();
    wait_cycles(Q);
    sampled = sda_line;
    wait_cycles(Q);
    scl_m = 1'b0;
    wait_cycles(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_cycles(Q);
    raise_scl();
    wait_cycles(Q);
    sda_m = 1'b0;
    wait_cycles(Q);
    scl_m = 1'b0;
    wait_cycles(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_cycles(Q);
    raise_scl();
    wait_cycles(Q);
    sda_m = 1'b1;
    wait_cycles(4 * Q);
  endtask

  task automatic applyStimulus(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clock_bit(nack, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       s;

    scl_m = 1'b1;
    sda_m = 1'b1;
    rst_n = 1'b0;
    clear_counters();
    wait_cycles(4);
    checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_cycles(4);
    checkOutput("idle_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("idle_scl_oe", 32'(scl_oe), 32'd0);
    checkOutput("idle_rw", 32'(rw), 32'd0);
    checkOutput("idle_rx_data", 32'(rx_data), 32'h00);
    checkOutput("idle_pulses", 32'({start_p, stop_p, rx_valid, tx_req}), 32'd0);

    // Write 0xA5, 0x3C to address 0x22.
    $display("[TB] write transfer");
    clear_counters();
    i2c_start();
    applyStimulus(8'h44, ack);
    checkOutput("wr_addr_ack", 32'(ack), 32'd1);
    checkOutput("wr_busy", 32'(busy), 32'd1);
    applyStimulus(8'hA5, ack);
    checkOutput("wr_d0_ack", 32'(ack), 32'd1);
    applyStimulus(8'h3C, ack);
    checkOutput("wr_d1_ack", 32'(ack), 32'd1);
    i2c_stop();
    checkOutput("wr_rx_count", 32'(rx_valid_cnt), 32'd2);
    if (rx_log.size() == 2) begin
      checkOutput("wr_rx0", 32'(rx_log[0]), 32'hA5);
      checkOutput("wr_rx1", 32'(rx_log[1]), 32'h3C);
    end else begin
      checkOutput("wr_rx_log_size", 32'(rx_log.size()), 32'd2);
    end
    checkOutput("wr_start_cnt", 32'(start_cnt), 32'd1);
    checkOutput("wr_stop_cnt", 32'(stop_cnt), 32'd1);
    checkOutput("wr_busy_after_stop", 32'(busy), 32'd0);
    checkOutput("wr_rw", 32'(rw), 32'd0);

    // Read two bytes, ACK then NACK.
    $display("[TB] read transfer");
    clear_counters();
    tx_bytes[0] = 8'h5A;
    tx_bytes[1] = 8'hC3;
    tx_idx   = 0;
    tx_delay = 2;
    i2c_start();
    applyStimulus(8'h45, ack);
    checkOutput("rd_addr_ack", 32'(ack), 32'd1);
    checkOutput("rd_rw", 32'(rw), 32'd1);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop();
    checkOutput("rd_byte0", 32'(d0), 32'h5A);
    checkOutput("rd_byte1", 32'(d1), 32'hC3);
    checkOutput("rd_tx_req_cnt", 32'(tx_req_cnt), 32'd2);
    checkOutput("rd_busy_after_stop", 32'(busy), 32'd0);
    checkOutput("rd_sda_released", 32'(sda_oe), 32'd0);

    // Foreign address 0x30: target must stay silent.
    $display("[TB] foreign address");
    clear_counters();
    i2c_start();
    applyStimulus(8'h60, ack);
    checkOutput("na_addr_ack", 32'(ack), 32'd0);
    applyStimulus(8'h12, ack);
    checkOutput("na_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    checkOutput("na_sda_oe_cycles", 32'(sda_oe_cycles), 32'd0);
    checkOutput("na_rx_valid_cnt", 32'(rx_valid_cnt), 32'd0);
    checkOutput("na_busy_cycles", 32'(busy_cycles), 32'd0);

    // Write one byte, repeated START, read one byte.
    $display("[TB] repeated start");
    clear_counters();
    tx_bytes[0] = 8'h81;
    tx_idx = 0;
    i2c_start();
    applyStimulus(8'h44, ack);
    checkOutput("rs_rw_write", 32'(rw), 32'd0);
    applyStimulus(8'h11, ack);
    checkOutput("rs_wr_ack", 32'(ack), 32'd1);
    i2c_start();
    applyStimulus(8'h45, ack);
    checkOutput("rs_rd_addr_ack", 32'(ack), 32'd1);
    checkOutput("rs_rw_read", 32'(rw), 32'd1);
    read_byte(1'b1, d0);
    i2c_stop();
    checkOutput("rs_start_cnt", 32'(start_cnt), 32'd2);
    checkOutput("rs_rx_data", 32'(rx_data), 32'h11);
    checkOutput("rs_rx_valid_cnt", 32'(rx_valid_cnt), 32'd1);
    checkOutput("rs_rd_byte", 32'(d0), 32'h81);

    // Read byte supplied 50 cycles late.
    $display("[TB] late read byte");
    clear_counters();
    tx_bytes[0] = 8'h3C;
    tx_idx   = 0;
    tx_delay = 50;
    scl_oe_at_valid    = 1'bx;
    scl_oe_after_valid = 1'bx;
    i2c_start();
    applyStimulus(8'h45, ack);
    read_byte(1'b1, d0);
    i2c_stop();
    tx_delay = 2;
    checkOutput("late_byte", 32'(d0), 32'(LATE_EXP));
    checkOutput("late_scl_oe_at_valid", 32'(scl_oe_at_valid), 32'(STRETCH));
    checkOutput("late_scl_oe_after_valid", 32'(scl_oe_after_valid), 32'd0);
    checkOutput("late_scl_oe_now", 32'(scl_oe), 32'd0);

    // STOP after 4 data bits of a write.
    $display("[TB] early stop");
    clear_counters();
    i2c_start();
    applyStimulus(8'h44, ack);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    i2c_stop();
    checkOutput("es_stop_cnt", 32'(stop_cnt), 32'd1);
    checkOutput("es_rx_valid_cnt", 32'(rx_valid_cnt), 32'd0);
    checkOutput("es_busy", 32'(busy), 32'd0);
    checkOutput("es_sda_oe", 32'(sda_oe), 32'd0);

    // Reset while the target is driving the address ACK.
    $display("[TB] reset during ack");
    clear_counters();
    i2c_start();
    for (int i = 7; i >= 0; i--) clock_bit(d0[0] ^ d0[0] ^ (8'h44 >> i) & 8'h01, s);
    checkOutput("ra_ack_driven", 32'(sda_oe), 32'd1);
    sda_m = 1'b1;
    wait_cycles(Q);
    raise_scl();
    wait_cycles(2);
    rst_n = 1'b0;
    #1;
    checkOutput("ra_sda_released", 32'(sda_oe), 32'd0);
    checkOutput("ra_busy", 32'(busy), 32'd0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(Q);
    scl_m = 1'b0;
    wait_cycles(Q);
    i2c_stop();
    checkOutput("ra_rx_valid_cnt", 32'(rx_valid_cnt), 32'd0);
    checkOutput("ra_sda_oe_idle", 32'(sda_oe), 32'd0);
    checkOutput("ra_rx_data", 32'(rx_data), 32'h00);

    checkOutput("scl_oe_used", 32'(scl_oe_cycles != 0), 32'(STRETCH));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
